// File: rtl/chip8_pkg.sv
// Shared constants, state encoding and hex font for the chip8 boot controller.
// The font table exists only when CHIP8_FONT_LOAD_EN is defined.
package chip8_pkg;

    localparam logic [11:0] FONT_BASE    = 12'h050;
    localparam logic [11:0] PROG_BASE    = 12'h200;
    localparam logic [11:0] MAX_PROG_LEN = 12'd3584;
    localparam logic [11:0] FONT_LEN     = 12'd80;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        FONT = 3'd1,
        PROG = 3'd2,
        RUN  = 3'd3,
        ERR  = 3'd4
    } state_t;

`ifdef CHIP8_FONT_LOAD_EN
    // Glyphs 0..F, five rows each, left-justified in the byte.
    localparam logic [7:0] FONT_TABLE [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };
`endif

endpackage

// File: rtl/chip8_tick_gen.sv
// Instruction and timer tick divider for the chip8 core; clear reloads both
// counters, a low enable freezes them with both ticks held low.
module chip8_tick_gen #(
    parameter int INSTR_DIV   = 50000,
    parameter int TIMER_RATIO = 9
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_instr_tick,
    output logic o_timer_tick
);

    localparam int DW = $clog2(INSTR_DIV);
    localparam int TW = $clog2(TIMER_RATIO + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(INSTR_DIV - 1);
    localparam logic [TW-1:0] RATIO_LAST = TW'(TIMER_RATIO - 1);

    logic [DW-1:0] r_div;
    logic [TW-1:0] r_ratio;
    logic          r_instr_tick;
    logic          r_timer_tick;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_div        <= DIV_LAST;
            r_ratio      <= '0;
            r_instr_tick <= 1'b0;
            r_timer_tick <= 1'b0;
        end else if (i_enable) begin
            if (r_div == '0) begin
                r_div        <= DIV_LAST;
                r_instr_tick <= 1'b1;
                if (r_ratio == RATIO_LAST) begin
                    r_ratio      <= '0;
                    r_timer_tick <= 1'b1;
                end else begin
                    r_ratio      <= r_ratio + 1'b1;
                    r_timer_tick <= 1'b0;
                end
            end else begin
                r_div        <= r_div - 1'b1;
                r_instr_tick <= 1'b0;
                r_timer_tick <= 1'b0;
            end
        end else begin
            r_instr_tick <= 1'b0;
            r_timer_tick <= 1'b0;
        end
    end

    assign o_instr_tick = r_instr_tick;
    assign o_timer_tick = r_timer_tick;

endmodule

// File: rtl/chip8_boot_ctrl.sv
// Boot/run sequencer: font load (when CHIP8_FONT_LOAD_EN is defined), program
// streaming into core memory, then core release and tick generation.
module chip8_boot_ctrl
    import chip8_pkg::*;
#(
    parameter int INSTR_DIV   = 50000,
    parameter int TIMER_RATIO = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [11:0] i_prog_len,
    input  logic        i_src_valid,
    input  logic [7:0]  i_src_data,
    output logic        o_src_ready,
    input  logic        i_pause,
    output logic        o_mem_we,
    output logic [11:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_core_rst,
    output logic        o_instr_tick,
    output logic        o_timer_tick,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output state_t      o_dbg_state
);

    // Byte source handshake: o_src_ready is registered and is high only in PROG
    // while bytes remain; a byte transfers on every edge where i_src_valid and
    // o_src_ready are both high. A start on that same edge wins and drops it.

    state_t      r_state, w_next;
    logic [11:0] r_cnt, w_cnt;
    logic [11:0] r_len, w_len;
    logic        r_mem_we, w_mem_we;
    logic [11:0] r_mem_addr, w_mem_addr;
    logic [7:0]  r_mem_wdata, w_mem_wdata;
    logic        r_src_ready, r_core_rst, r_busy, r_done, r_error;
    logic        w_len_ok, w_accept, w_tick_en, w_tick_clr;

    assign w_len_ok = (i_prog_len <= MAX_PROG_LEN);
    assign w_accept = (r_state == PROG) && r_src_ready && i_src_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_start) begin
`ifdef CHIP8_FONT_LOAD_EN
            w_next = w_len_ok ? FONT : ERR;
`else
            w_next = !w_len_ok ? ERR : ((i_prog_len == '0) ? RUN : PROG);
`endif
        end else begin
            case (r_state)
`ifdef CHIP8_FONT_LOAD_EN
                FONT: if (r_cnt == FONT_LEN) w_next = (r_len == '0) ? RUN : PROG;
`endif
                PROG: if (w_accept && (r_cnt + 12'd1 == r_len)) w_next = RUN;
                default: ;
            endcase
        end
    end

    // Next values of the registered outputs; r_cnt is the font index k in
    // FONT and the program byte index n in PROG.
    always_comb begin
        w_cnt       = r_cnt;
        w_len       = r_len;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_mem_addr;
        w_mem_wdata = r_mem_wdata;
        if (i_start) begin
            w_len = i_prog_len;
            w_cnt = '0;
`ifdef CHIP8_FONT_LOAD_EN
            if (w_len_ok) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = FONT_BASE;
                w_mem_wdata = FONT_TABLE[0];
                w_cnt       = 12'd1;
            end
`endif
        end else begin
            case (r_state)
`ifdef CHIP8_FONT_LOAD_EN
                FONT: begin
                    if (r_cnt != FONT_LEN) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = FONT_BASE + r_cnt;
                        w_mem_wdata = FONT_TABLE[r_cnt[6:0]];
                        w_cnt       = r_cnt + 12'd1;
                    end else begin
                        w_cnt = '0;
                    end
                end
`endif
                PROG: begin
                    if (w_accept) begin
                        w_mem_we    = 1'b1;
                        w_mem_addr  = PROG_BASE + r_cnt;
                        w_mem_wdata = i_src_data;
                        w_cnt       = r_cnt + 12'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt       <= '0;
            r_len       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_src_ready <= 1'b0;
            r_core_rst  <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_cnt       <= w_cnt;
            r_len       <= w_len;
            r_mem_we    <= w_mem_we;
            r_mem_addr  <= w_mem_addr;
            r_mem_wdata <= w_mem_wdata;
            r_src_ready <= (w_next == PROG);
            r_core_rst  <= (w_next != RUN);
            r_busy      <= (w_next == FONT) || (w_next == PROG);
            r_done      <= (w_next == RUN);
            r_error     <= (w_next == ERR);
        end
    end

    // The divider starts counting on the first cycle spent in RUN; a start
    // clears it on the same edge that leaves RUN.
    assign w_tick_en  = !i_pause;
    assign w_tick_clr = (r_state != RUN) || i_start;

    chip8_tick_gen #(
        .INSTR_DIV   (INSTR_DIV),
        .TIMER_RATIO (TIMER_RATIO)
    ) u_tick_gen (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_enable     (w_tick_en),
        .i_clear      (w_tick_clr),
        .o_instr_tick (o_instr_tick),
        .o_timer_tick (o_timer_tick)
    );

    assign o_src_ready = r_src_ready;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_core_rst  = r_core_rst;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_chip8_boot_ctrl.sv
// Directed bench for chip8_boot_ctrl; memory writes are checked against a
// queue of expected {addr,data} pairs. Handles both CHIP8_FONT_LOAD_EN builds.
module tb_chip8_boot_ctrl;

    localparam int INSTR_DIV   = 4;
    localparam int TIMER_RATIO = 9;
`ifdef CHIP8_FONT_LOAD_EN
    localparam int FL = 80;
`else
    localparam int FL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, src_valid, pause;
    logic [11:0] prog_len;
    logic [7:0]  src_data;
    logic        src_ready, mem_we, core_rst, instr_tick, timer_tick;
    logic        busy, done, error;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [2:0]  dbg_state;

    logic [19:0] exp_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_it;
    int          t;
    logic        it_exp, tt_exp;

    logic [7:0] font_ref [80] = '{
        8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
        8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
        8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
        8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
        8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
    };

    chip8_boot_ctrl #(
        .INSTR_DIV   (INSTR_DIV),
        .TIMER_RATIO (TIMER_RATIO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_prog_len   (prog_len),
        .i_src_valid  (src_valid),
        .i_src_data   (src_data),
        .o_src_ready  (src_ready),
        .i_pause      (pause),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_core_rst   (core_rst),
        .o_instr_tick (instr_tick),
        .o_timer_tick (timer_tick),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_dbg_state  (dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        logic [20:0] e;
        if (mem_we === 1'b1) begin
            if (exp_q.size() > 0) e = {1'b0, exp_q.pop_front()};
            else                  e = {1'b1, 20'h0};
            chk("mem_write", {11'h0, 1'b0, mem_addr, mem_wdata}, {11'h0, e});
        end
    end

    // Driver tasks
    task automatic do_start(input logic [11:0] len);
        start    = 1'b1;
        prog_len = len;
`ifdef CHIP8_FONT_LOAD_EN
        if (len <= 12'd3584)
            for (int k = 0; k < 80; k++) exp_q.push_back({12'h050 + 12'(k), font_ref[k]});
`endif
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [11:0] a);
        int w;
        w         = 0;
        src_valid = 1'b1;
        src_data  = d;
        while (src_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", (w < 200), 1);
        if (w < 200) exp_q.push_back({a, d});
        @(negedge clk);
        src_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        chk({pfx, "_mem_we"}, mem_we, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wdata"}, mem_wdata, 0);
        chk({pfx, "_src_ready"}, src_ready, 0);
        chk({pfx, "_instr_tick"}, instr_tick, 0);
        chk({pfx, "_timer_tick"}, timer_tick, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_error"}, error, 0);
        chk({pfx, "_core_rst"}, core_rst, 1);
        chk({pfx, "_state"}, dbg_state, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; prog_len = '0;
        src_valid = 1'b0; src_data = '0; pause = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Font load with empty program, then tick cadence in RUN
        do_start(12'd0);
`ifdef CHIP8_FONT_LOAD_EN
        chk("font_first_we", mem_we, 1);
        chk("font_first_addr", mem_addr, 12'h050);
        chk("font_busy", busy, 1);
        chk("font_core_rst", core_rst, 1);
        repeat (79) @(negedge clk);
        chk("font_last_we", mem_we, 1);
        chk("font_last_addr", mem_addr, 12'h09F);
        @(negedge clk);
`endif
        chk("run_core_rst", core_rst, 0);
        chk("run_done", done, 1);
        chk("run_busy", busy, 0);
        chk("run_mem_we", mem_we, 0);
        n_it = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            it_exp = (c % INSTR_DIV == 0);
            if (it_exp) n_it++;
            tt_exp = it_exp && (n_it % TIMER_RATIO == 0);
            chk($sformatf("instr_tick_c%0d", c), instr_tick, it_exp);
            chk($sformatf("timer_tick_c%0d", c), timer_tick, tt_exp);
        end

        // Program stream with gaps; start also leaves RUN here
        do_start(12'd3);
        chk("leave_run_core_rst", core_rst, 1);
        chk("leave_run_done", done, 0);
        chk("leave_run_tick", instr_tick, 0);
        repeat (FL) @(negedge clk);
        chk("prog_ready_first", src_ready, 1);
        send_byte(8'h12, 12'h200);
        repeat (2) @(negedge clk);
        send_byte(8'h34, 12'h201);
        repeat (2) @(negedge clk);
        send_byte(8'h56, 12'h202);
        chk("prog_ready_drop", src_ready, 0);
        chk("prog_done", done, 1);
        chk("prog_core_rst", core_rst, 0);
        chk("prog_busy", busy, 0);

        // Illegal length, then recovery
        do_start(12'd3585);
        chk("err_error", error, 1);
        chk("err_core_rst", core_rst, 1);
        chk("err_done", done, 0);
        chk("err_busy", busy, 0);
        chk("err_ready", src_ready, 0);
        repeat (5) @(negedge clk);
        chk("err_hold", error, 1);
        chk("err_state", dbg_state, 4);
        do_start(12'd2);
        chk("recover_error", error, 0);
        chk("recover_core_rst", core_rst, 1);
        repeat (FL) @(negedge clk);
        send_byte(8'hA1, 12'h200);
        send_byte(8'hB2, 12'h201);
        chk("recover_done", done, 1);

        // Abort mid-program, then a full reload of 10 bytes
        do_start(12'd10);
        repeat (FL) @(negedge clk);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h40 + i), 12'(12'h200 + i));
        chk("abort_pre_core_rst", core_rst, 1);
        chk("abort_pre_busy", busy, 1);
        do_start(12'd10);
        chk("abort_core_rst", core_rst, 1);
        chk("abort_done", done, 0);
`ifdef CHIP8_FONT_LOAD_EN
        chk("abort_font_addr", mem_addr, 12'h050);
        chk("abort_font_we", mem_we, 1);
`else
        chk("abort_ready", src_ready, 1);
`endif
        repeat (FL) @(negedge clk);
        for (int i = 0; i < 10; i++) send_byte(8'(i * 7 + 3), 12'(12'h200 + i));
        chk("abort_reload_done", done, 1);

        // Pause for 10 cycles right after an instruction tick
        t = 0;
        while (instr_tick !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("pause_tick_found", (t < 20), 1);
        @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("pause_instr_%0d", i), instr_tick, 0);
            chk($sformatf("pause_timer_%0d", i), timer_tick, 0);
        end
        pause = 1'b0;
        @(negedge clk);
        chk("resume_tick_1", instr_tick, 0);
        @(negedge clk);
        chk("resume_tick_2", instr_tick, 0);
        @(negedge clk);
        chk("resume_tick_3", instr_tick, 1);

        // Reset mid-program; source keeps offering data afterwards
        do_start(12'd4);
        repeat (FL) @(negedge clk);
        send_byte(8'hC1, 12'h200);
        send_byte(8'hC2, 12'h201);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_mid");
        src_valid = 1'b1;
        src_data  = 8'hEE;
        repeat (20) @(negedge clk);
        chk("rst_mid_ready_after", src_ready, 0);
        chk("rst_mid_core_rst_after", core_rst, 1);
        src_valid = 1'b0;

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
